// File: rtl/plant_responder.sv
`default_nettype none
// ============================================================================
// Module : plant_responder
// Brief  : Registered plant model: request, motor travel, arrival, verify, watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module plant_responder #(
  parameter int TRAVEL  = 8,
  parameter int TIMEOUT = 16,
  parameter int POS_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic             LEDS,
  input  logic             LEDC,
  output logic             C,
  output logic             S,
  output logic             V,
  output logic             busy,
  output logic             fault,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_RUN     = 3'd2,
    ST_ARRIVED = 3'd3,
    ST_VERIFY  = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [POS_W-1:0] c_TRAVEL  = POS_W'(TRAVEL);
  localparam logic [7:0]       c_TIMEOUT = 8'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wcnt;
  logic [7:0]       w_wcnt_nxt;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_nxt;
  logic [POS_W-1:0] w_pos_inc;
  logic             r_C;
  logic             r_S;
  logic             r_V;
  logic             r_busy;
  logic             r_fault;
  logic             w_V_nxt;
  logic             w_waiting;
  logic             w_timeout;

  assign w_pos_inc = r_pos + POS_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_V_nxt     = 1'b0;
    w_waiting   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_REQUEST;
          w_pos_nxt   = '0;
        end
      end
      ST_REQUEST: begin
        w_waiting = 1'b1;
        if (LEDS)   w_state_nxt = ST_IDLE;
        else if (M) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_waiting = ~M;
        if (LEDS) begin
          w_state_nxt = ST_IDLE;
        end else if (M) begin
          if (w_pos_inc >= c_TRAVEL) begin
            w_pos_nxt   = c_TRAVEL;
            w_state_nxt = ST_ARRIVED;
          end else begin
            w_pos_nxt = w_pos_inc;
          end
        end
      end
      ST_ARRIVED: begin
        w_waiting = 1'b1;
        if (!M) w_state_nxt = ST_VERIFY;
      end
      ST_VERIFY: begin
        // V is a one-cycle pulse; the cycle after it is raised we return to IDLE
        w_waiting = 1'b1;
        if (r_V)       w_state_nxt = ST_IDLE;
        else if (LEDC) w_V_nxt = 1'b1;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_timeout = (r_state != ST_IDLE) && (r_state != ST_FAULT) && (r_wcnt >= c_TIMEOUT);
    if (w_timeout) begin
      w_state_nxt = ST_FAULT;
      w_pos_nxt   = r_pos;
      w_V_nxt     = 1'b0;
    end

    if (w_state_nxt != r_state) w_wcnt_nxt = 8'd0;
    else if (w_waiting)         w_wcnt_nxt = r_wcnt + 8'd1;
    else                        w_wcnt_nxt = r_wcnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 8'd0;
      r_pos   <= '0;
      r_C     <= 1'b0;
      r_S     <= 1'b0;
      r_V     <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_pos   <= w_pos_nxt;
      r_C     <= (w_state_nxt == ST_REQUEST);
      r_S     <= (w_state_nxt == ST_ARRIVED);
      r_V     <= w_V_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FAULT);
      r_fault <= (w_state_nxt == ST_FAULT);
    end
  end

  assign C     = r_C;
  assign S     = r_S;
  assign V     = r_V;
  assign busy  = r_busy;
  assign fault = r_fault;
  assign pos   = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_plant_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_plant_responder
// Brief  : Directed and random closed-loop checks of plant_responder (TRAVEL=8 and TRAVEL=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_plant_responder;

  localparam int TO     = 16;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_RUN  = 2;
  localparam int P_ARR  = 3;
  localparam int P_VER  = 4;
  localparam int P_FLT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st_a = 1'b0, m_a = 1'b0, ls_a = 1'b0, lc_a = 1'b0;
  logic st_b = 1'b0, m_b = 1'b0, ls_b = 1'b0, lc_b = 1'b0;
  logic C_a, S_a, V_a, busy_a, fault_a;
  logic C_b, S_b, V_b, busy_b, fault_b;
  logic [7:0] pos_a, pos_b;

  int n_checks = 0;
  int n_err    = 0;

  int m_ph[2];
  int m_pos[2];
  int m_wait[2];
  bit m_v[2];
  int m_trav[2] = '{8, 1};

  always #5 clk = ~clk;

  plant_responder #(.TRAVEL(8), .TIMEOUT(TO), .POS_W(8)) u_a (
    .clk(clk), .rst(rst), .start(st_a), .M(m_a), .LEDS(ls_a), .LEDC(lc_a),
    .C(C_a), .S(S_a), .V(V_a), .busy(busy_a), .fault(fault_a), .pos(pos_a)
  );

  plant_responder #(.TRAVEL(1), .TIMEOUT(TO), .POS_W(8)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .M(m_b), .LEDS(ls_b), .LEDC(lc_b),
    .C(C_b), .S(S_b), .V(V_b), .busy(busy_b), .fault(fault_b), .pos(pos_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int k);
    if (k == 0) return {19'd0, C_a, S_a, V_a, busy_a, fault_a, pos_a};
    else        return {19'd0, C_b, S_b, V_b, busy_b, fault_b, pos_b};
  endfunction

  function automatic logic [31:0] exp_outs(input int k);
    logic [31:0] r;
    r       = '0;
    r[12]   = (m_ph[k] == P_REQ);
    r[11]   = (m_ph[k] == P_ARR);
    r[10]   = m_v[k];
    r[9]    = (m_ph[k] >= P_REQ) && (m_ph[k] <= P_VER);
    r[8]    = (m_ph[k] == P_FLT);
    r[7:0]  = 8'(m_pos[k]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k]   = P_IDLE;
      m_pos[k]  = 0;
      m_wait[k] = 0;
      m_v[k]    = 1'b0;
    end
  endtask

  // Reference behaviour: one rising edge with the inputs the plant sees on that edge
  task automatic model_edge(input int k, input logic st, input logic m, input logic ls, input logic lc);
    int ph;
    int nph;
    int p;
    bit v;
    bit waiting;
    ph      = m_ph[k];
    nph     = ph;
    p       = m_pos[k];
    v       = 1'b0;
    waiting = (ph == P_REQ) || (ph == P_RUN && !m) || (ph == P_ARR) || (ph == P_VER);
    if (ph >= P_REQ && ph <= P_VER && m_wait[k] >= TO) begin
      nph = P_FLT;
    end else begin
      case (ph)
        P_IDLE: if (st) begin nph = P_REQ; p = 0; end
        P_REQ:  if (ls) nph = P_IDLE; else if (m) nph = P_RUN;
        P_RUN: begin
          if (ls) nph = P_IDLE;
          else if (m) begin
            p = (p + 1 >= m_trav[k]) ? m_trav[k] : p + 1;
            if (p == m_trav[k]) nph = P_ARR;
          end
        end
        P_ARR:  if (!m) nph = P_VER;
        P_VER:  if (m_v[k]) nph = P_IDLE; else if (lc) v = 1'b1;
        default: ;
      endcase
    end
    m_wait[k] = (nph != ph) ? 0 : (waiting ? m_wait[k] + 1 : m_wait[k]);
    m_ph[k]   = nph;
    m_pos[k]  = p;
    m_v[k]    = v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, st_a, m_a, ls_a, lc_a);
    model_edge(1, st_b, m_b, ls_b, lc_b);
    #1;
    chk("model_a", outs(0), exp_outs(0));
    chk("model_b", outs(1), exp_outs(1));
  endtask

  // Reset is raised and released between clock edges; outputs must clear without an edge
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_a", outs(0), 32'd0);
    chk("rst_b", outs(1), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    async_reset();

    // nominal cycle
    st_a = 1'b1; tick();
    chk1("nom_C_rise", C_a, 1'b1);
    chk1("nom_busy_rise", busy_a, 1'b1);
    st_a = 1'b0; tick();
    chk1("nom_C_2nd", C_a, 1'b1);
    m_a = 1'b1; tick();
    chk1("nom_C_drop", C_a, 1'b0);
    chk("nom_pos0", 32'(pos_a), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("nom_pos", 32'(pos_a), 32'(i));
      chk1("nom_S", S_a, (i == 8));
    end
    tick();
    chk1("nom_S_hold", S_a, 1'b1);
    m_a = 1'b0; tick();
    chk1("nom_S_drop", S_a, 1'b0);
    chk1("nom_busy_ver", busy_a, 1'b1);
    lc_a = 1'b1; tick();
    chk1("nom_V", V_a, 1'b1);
    lc_a = 1'b0; tick();
    chk1("nom_V_end", V_a, 1'b0);
    chk1("nom_busy_end", busy_a, 1'b0);
    chk1("nom_fault", fault_a, 1'b0);

    // paused travel
    st_a = 1'b1; tick();
    st_a = 1'b0; m_a = 1'b1; tick();
    repeat (4) tick();
    chk("pause_pos4", 32'(pos_a), 32'd4);
    m_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_hold", 32'(pos_a), 32'd4);
    end
    m_a = 1'b1;
    repeat (4) tick();
    chk("pause_pos8", 32'(pos_a), 32'd8);
    chk1("pause_S", S_a, 1'b1);
    m_a = 1'b0; tick();
    lc_a = 1'b1; tick();
    lc_a = 1'b0; tick();

    // abort in RUN at pos 5
    st_a = 1'b1; tick();
    st_a = 1'b0; m_a = 1'b1; tick();
    repeat (5) tick();
    chk("abort_pos5", 32'(pos_a), 32'd5);
    ls_a = 1'b1; tick();
    chk("abort_outs", outs(0), {19'd0, 5'b00000, 8'd5});
    ls_a = 1'b0; m_a = 1'b0; st_a = 1'b1; tick();
    chk("abort_restart_pos", 32'(pos_a), 32'd0);
    chk1("abort_restart_C", C_a, 1'b1);
    st_a = 1'b0; m_a = 1'b1; ls_a = 1'b1; tick();
    chk1("abort_wins_busy", busy_a, 1'b0);
    m_a = 1'b0; ls_a = 1'b0;

    // timeout in REQUEST
    st_a = 1'b1; tick();
    st_a = 1'b0; cnt = 1;
    for (int i = 0; i < 40 && !fault_a; i++) begin
      tick();
      if (C_a) cnt++;
    end
    chk("to_C_cycles", 32'(cnt), 32'd17);
    chk1("to_fault", fault_a, 1'b1);
    chk1("to_C_low", C_a, 1'b0);
    st_a = 1'b1;
    repeat (3) tick();
    chk("to_sticky", outs(0), {19'd0, 5'b00001, 8'd0});
    st_a = 1'b0;

    // asynchronous reset mid-RUN at pos 3
    async_reset();
    tick();
    st_a = 1'b1; tick();
    st_a = 1'b0; m_a = 1'b1; tick();
    repeat (3) tick();
    chk("ar_pos3", 32'(pos_a), 32'd3);
    m_a = 1'b0;
    async_reset();
    tick();
    chk("ar_after", outs(0), 32'd0);

    // TRAVEL=1 boundary and VERIFY timeout
    st_b = 1'b1; tick();
    st_b = 1'b0; m_b = 1'b1; tick();
    tick();
    chk("b_pos1", 32'(pos_b), 32'd1);
    chk1("b_S", S_b, 1'b1);
    m_b = 1'b0; tick();
    chk1("b_S_drop", S_b, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40 && !fault_b; i++) begin
      tick();
      cnt++;
    end
    chk("b_to_cycles", 32'(cnt), 32'd17);
    chk1("b_fault", fault_b, 1'b1);

    // random closed-loop traffic against the model
    async_reset();
    for (int n = 0; n < 600; n++) begin
      st_a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) m_a = ~m_a;
      ls_a = ($urandom_range(0, 19) == 0);
      lc_a = ($urandom_range(0, 2) == 0);
      st_b = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) m_b = ~m_b;
      ls_b = ($urandom_range(0, 19) == 0);
      lc_b = ($urandom_range(0, 2) == 0);
      tick();
      if ((m_ph[0] == P_FLT || m_ph[1] == P_FLT) && $urandom_range(0, 3) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plant_responder.md
# plant_responder

Plant-side responder for `statemachine`: a registered model of the motorised mechanism and operator panel the controller drives. It raises the request input `C`, counts motor travel while `M` is high, reports arrival on `S`, and pulses `V` once the controller confirms completion on `LEDC`. A timeout watchdog flags a stalled controller. It replaces hand-written stimulus in closed-loop benches and on the board.

## Interface
- `TRAVEL`, default 8: motor-on cycles from position 0 to arrival; legal range 1 .. 2^POS_W-1.
- `TIMEOUT`, default 16: maximum wait cycles in any waiting state before fault; legal range 1 .. 255.
- `POS_W`, default 8: width of the position counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: operator command, level-sampled in IDLE.
- `M` input 1: motor enable from controller.
- `LEDS` input 1: controller stop/abort indicator.
- `LEDC` input 1: controller completion indicator.
- `C` output 1: cycle request to controller.
- `S` output 1: arrival sensor to controller.
- `V` output 1: verify pulse to controller.
- `busy` output 1: high in every state except IDLE and FAULT.
- `fault` output 1: sticky watchdog error.
- `pos` output POS_W: current mechanism position.

## Operation
- States: IDLE, REQUEST, RUN, ARRIVED, VERIFY, FAULT. All outputs are registered.
- Wait counter `wcnt` (8 bits): cleared on every state change, incremented each cycle spent in REQUEST, in RUN with M=0, in ARRIVED, or in VERIFY. When it reaches TIMEOUT, the next state is FAULT.
- IDLE: C=S=V=0, pos holds. If start=1, next state is REQUEST and pos clears to 0.
- REQUEST: C=1. M=1 moves to RUN. LEDS=1 moves to IDLE.
- RUN: C=0.
  - M=1: pos increments by 1.
  - M=0: pos holds (paused).
  - When pos would reach TRAVEL, pos loads TRAVEL, S goes to 1, and the next state is ARRIVED.
  - LEDS=1 takes priority over increment: next state IDLE, pos holds.
- ARRIVED: S=1, pos holds. M=0 moves to VERIFY and S clears.
- VERIFY: waits for LEDC=1. Then V=1 for exactly one cycle and the next state is IDLE.
- FAULT: fault=1, C=S=V=0, pos holds. Exits only on rst; start is ignored.
- Priority within one cycle: rst, then timeout, then LEDS abort, then the normal transition.
- pos never exceeds TRAVEL and never wraps.

## Timing
- Reset values: state IDLE, C=0, S=0, V=0, busy=0, fault=0, pos=0, wcnt=0. Reset mid-operation returns to these values immediately, without waiting for a clock edge.
- start high at edge k: C=1 and busy=1 after edge k.
- M first sampled high at edge j in REQUEST: C=0 after j; pos=1 after edge j+1.
- With M held high, S=1 appears after edge j+TRAVEL, in the same cycle pos=TRAVEL.
- M sampled low at edge a in ARRIVED: S=0 after a.
- LEDC sampled high at edge b in VERIFY: V=1 after b, V=0 and busy=0 after b+1.
- Timeout: fault=1 after the edge on which wcnt was TIMEOUT, i.e. TIMEOUT+1 cycles of unbroken waiting after state entry.
- start held high continuously: a new REQUEST begins one cycle after returning to IDLE.
- Simultaneous M=1 and LEDS=1 in REQUEST: abort to IDLE wins.
- Simultaneous M=0 and LEDS=1 in ARRIVED: LEDS is ignored and the block goes to VERIFY.

## Test plan
- Nominal cycle, TRAVEL=8: start pulse; controller raises M 2 cycles later, drops it 1 cycle after S, and raises LEDC 1 cycle later.
  - Required: C high 2 cycles; pos counts 1..8; S high 2 cycles; V one-cycle pulse; busy low afterwards; fault=0.
- Paused travel: M dropped for 3 cycles at pos=4, then restored.
  - Required: pos holds at 4 for 3 cycles, resumes, and reaches 8. Total motor-on cycles equal 8.
- Abort: LEDS=1 at pos=5 in RUN.
  - Required: IDLE next cycle, pos stays 5, C=S=V=0, busy=0. A new start clears pos to 0.
- Timeout, TIMEOUT=16: start with M never raised.
  - Required: C high for 17 cycles, then fault=1, C=0.
  - Further start pulses are ignored until rst; after rst all outputs are 0.
- Asynchronous reset mid-RUN at pos=3, asserted between clock edges.
  - Required: all outputs 0 before the next edge; after release, IDLE with pos=0.
- Boundary, TRAVEL=1: M raised in REQUEST.
  - Required: pos=1 and S=1 together after the first motor-on edge. VERIFY timeout with LEDC never high sets fault after 17 cycles.
